// File: rtl/buffered_router_if.sv
// buffered_router_if: bundles the producer-side and consumer-side handshake signals
// of buffered_router.
//   din/din_en/addr/din_ready : single input stream and its channel select
//   dout/dout_valid/dout_ready: per-channel first-word-fall-through outputs
//   occupancy                 : per-channel word count, 0..FIFO_DEPTH
//   drop_err                  : one-cycle pulse when an out-of-range word is discarded
// The master modport is the environment (producer + consumers); the slave modport is the router.
interface buffered_router_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned AW = $clog2(NUM_PORTS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_WIDTH-1:0]           din;
  logic                            din_en;
  logic [AW-1:0]                   addr;
  logic                            din_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] dout;
  logic [NUM_PORTS-1:0]            dout_valid;
  logic [NUM_PORTS-1:0]            dout_ready;
  logic [NUM_PORTS*CW-1:0]         occupancy;
  logic                            drop_err;

  modport master (
    output din, din_en, addr, dout_ready,
    input  din_ready, dout, dout_valid, occupancy, drop_err
  );

  modport slave (
    input  din, din_en, addr, dout_ready,
    output din_ready, dout, dout_valid, occupancy, drop_err
  );
endinterface

// File: rtl/buffered_router.sv
// buffered_router: routes one valid/ready word stream to NUM_PORTS output channels chosen by
// addr, each behind its own FIFO_DEPTH-word first-word-fall-through FIFO.
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset (pointers, counts and drop_err cleared)
//   bus    : buffered_router_if slave modport carrying all data/handshake signals
// Words to an out-of-range addr are accepted, discarded and flagged on drop_err next cycle.
module buffered_router #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              resetn,
  buffered_router_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_PORTS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q [NUM_PORTS];
  logic [PW-1:0]         rd_ptr_q [NUM_PORTS];
  logic [CW-1:0]         count_q  [NUM_PORTS];
  logic                  drop_err_q;

  logic [NUM_PORTS-1:0]  full;
  logic [NUM_PORTS-1:0]  valid;
  logic [NUM_PORTS-1:0]  push;
  logic [NUM_PORTS-1:0]  pop;
  logic                  in_range;

  // Channel decode. din_ready looks only at full, never at a same-cycle pop, so a full
  // FIFO refuses input even while draining. Out-of-range addresses are always ready.
  always_comb begin
    full          = '0;
    valid         = '0;
    push          = '0;
    pop           = '0;
    in_range      = 1'b0;
    bus.din_ready = 1'b1;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      full[k]  = (count_q[k] == CW'(FIFO_DEPTH));
      valid[k] = (count_q[k] != '0);
      pop[k]   = valid[k] & bus.dout_ready[k];
      if (bus.addr == AW'(k)) begin
        in_range      = 1'b1;
        bus.din_ready = ~full[k];
        push[k]       = bus.din_en & ~full[k];
      end
    end
  end

  // Fall-through outputs; an empty channel reads as zero.
  always_comb begin
    bus.dout      = '0;
    bus.occupancy = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (valid[k]) begin
        bus.dout[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[k][rd_ptr_q[k]];
      end
      bus.occupancy[k*CW +: CW] = count_q[k];
    end
  end

  assign bus.dout_valid = valid;
  assign bus.drop_err   = drop_err_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        count_q[k]  <= '0;
      end
      drop_err_q <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PW'(1);
        if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + PW'(1);
        count_q[k] <= count_q[k] + CW'(push[k]) - CW'(pop[k]);
      end
      drop_err_q <= bus.din_en & ~in_range;
    end
  end

  // Storage needs no reset: a slot is only visible once its count covers it.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (push[k]) mem_q[k][wr_ptr_q[k]] <= bus.din;
    end
  end
endmodule

// File: tb/tb_buffered_router.sv
// tb_buffered_router: drives one shared stimulus stream into a 4-port and a 3-port router
// and checks both every cycle against queue-based reference models.
module tb_buffered_router;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 4;
  localparam int unsigned CW = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] din = '0;
  logic          din_en = 1'b0;
  logic [1:0]    addr = '0;
  logic [3:0]    rdy = '0;

  buffered_router_if #(.DATA_WIDTH(DW), .NUM_PORTS(4), .FIFO_DEPTH(FD)) bus4 ();
  buffered_router_if #(.DATA_WIDTH(DW), .NUM_PORTS(3), .FIFO_DEPTH(FD)) bus3 ();

  assign bus4.din        = din;
  assign bus4.din_en     = din_en;
  assign bus4.addr       = addr;
  assign bus4.dout_ready = rdy;
  assign bus3.din        = din;
  assign bus3.din_en     = din_en;
  assign bus3.addr       = addr;
  assign bus3.dout_ready = rdy[2:0];

  buffered_router #(.DATA_WIDTH(DW), .NUM_PORTS(4), .FIFO_DEPTH(FD)) u_dut4 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus4)
  );

  buffered_router #(.DATA_WIDTH(DW), .NUM_PORTS(3), .FIFO_DEPTH(FD)) u_dut3 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus3)
  );

  // Reference model: one queue per channel, head at index 0.
  logic [DW-1:0] q4 [4][$];
  logic [DW-1:0] q3 [3][$];
  logic          drop4_exp = 1'b0;
  logic          drop3_exp = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ready4();
    return q4[addr].size() < FD;
  endfunction

  function automatic logic ready3();
    if (addr == 2'd3) return 1'b1;
    return q3[addr].size() < FD;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) q4[k].delete();
    for (int k = 0; k < 3; k++) q3[k].delete();
    drop4_exp = 1'b0;
    drop3_exp = 1'b0;
  endtask

  // Applies one clock edge to the model; readiness uses the state before the edge.
  task automatic model_step();
    logic acc4;
    logic acc3;
    acc4 = din_en && ready4();
    acc3 = din_en && ready3();
    for (int k = 0; k < 4; k++) if (rdy[k] && q4[k].size() != 0) void'(q4[k].pop_front());
    for (int k = 0; k < 3; k++) if (rdy[k] && q3[k].size() != 0) void'(q3[k].pop_front());
    if (acc4) q4[addr].push_back(din);
    if (acc3 && addr != 2'd3) q3[addr].push_back(din);
    drop4_exp = 1'b0;
    drop3_exp = din_en && (addr == 2'd3);
  endtask

  task automatic check_all();
    logic [3:0] v4;
    logic [2:0] v3;
    for (int k = 0; k < 4; k++) begin
      v4[k] = q4[k].size() != 0;
      check($sformatf("p4_dout%0d", k), 64'(bus4.dout[k*DW +: DW]),
            v4[k] ? 64'(q4[k][0]) : 64'd0);
      check($sformatf("p4_occ%0d", k), 64'(bus4.occupancy[k*CW +: CW]), 64'(q4[k].size()));
    end
    for (int k = 0; k < 3; k++) begin
      v3[k] = q3[k].size() != 0;
      check($sformatf("p3_dout%0d", k), 64'(bus3.dout[k*DW +: DW]),
            v3[k] ? 64'(q3[k][0]) : 64'd0);
      check($sformatf("p3_occ%0d", k), 64'(bus3.occupancy[k*CW +: CW]), 64'(q3[k].size()));
    end
    check("p4_valid", 64'(bus4.dout_valid), 64'(v4));
    check("p3_valid", 64'(bus3.dout_valid), 64'(v3));
    check("p4_drop", 64'(bus4.drop_err), 64'(drop4_exp));
    check("p3_drop", 64'(bus3.drop_err), 64'(drop3_exp));
    check("p4_ready", 64'(bus4.din_ready), 64'(ready4()));
    check("p3_ready", 64'(bus3.din_ready), 64'(ready3()));
  endtask

  // Called just after a rising edge with inputs already applied.
  task automatic cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drive(input logic en, input logic [1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] r);
    din_en = en;
    addr   = a;
    din    = d;
    rdy    = r;
    cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_v4"}, 64'(bus4.dout_valid), 64'd0);
    check({tag, "_v3"}, 64'(bus3.dout_valid), 64'd0);
    check({tag, "_d4"}, 64'(bus4.dout), 64'd0);
    check({tag, "_d3"}, 64'(bus3.dout), 64'd0);
    check({tag, "_o4"}, 64'(bus4.occupancy), 64'd0);
    check({tag, "_o3"}, 64'(bus3.occupancy), 64'd0);
    check({tag, "_e4"}, 64'(bus4.drop_err), 64'd0);
    check({tag, "_e3"}, 64'(bus3.drop_err), 64'd0);
  endtask

  // Entered just after a rising edge; resetn falls mid-cycle and outputs must clear at once.
  task automatic async_reset();
    din_en = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_clear();
    @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("in_rst");
    @(negedge clk) resetn = 1'b1;
    @(posedge clk);
    #1;
    repeat (5) drive(1'b0, 2'd0, '0, 4'h0);

    // One word per channel; lane k valid one edge after its push
    drive(1'b1, 2'd0, 32'h1111_0000, 4'h0);
    check("lane0_after_push", 64'(bus4.dout[0 +: DW]), 64'h1111_0000);
    drive(1'b1, 2'd1, 32'h2222_0000, 4'h0);
    drive(1'b1, 2'd2, 32'h3333_0000, 4'h0);
    drive(1'b1, 2'd3, 32'h4444_0000, 4'h0);
    check("lane3_after_push", 64'(bus4.dout[3*DW +: DW]), 64'h4444_0000);
    check("all_valid", 64'(bus4.dout_valid), 64'hF);
    check("all_occ1", 64'(bus4.occupancy), 64'h249);
    drive(1'b0, 2'd0, '0, 4'h0);

    // Drain everything
    repeat (2) drive(1'b0, 2'd0, '0, 4'hF);

    // Fill channel 2, then refuse a fifth word until a slot frees
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd2, 32'hA0 + 32'(i), 4'h0);
    din_en = 1'b1;
    addr   = 2'd2;
    din    = 32'hA4;
    rdy    = 4'h0;
    #1;
    check("full_ready", 64'(bus4.din_ready), 64'd0);
    check("full_occ2", 64'(bus4.occupancy[2*CW +: CW]), 64'd4);
    for (int i = 0; i < 4; i++) begin
      din_en = (i < 2);
      rdy    = 4'b0100;
      #1;
      check("drain_order", 64'(bus4.dout[2*DW +: DW]), 64'hA0 + 64'(i));
      if (i < 2) check("fifth_ready", 64'(bus4.din_ready), (i == 0) ? 64'd0 : 64'd1);
      cycle();
    end
    check("fifth_head", 64'(bus4.dout[2*DW +: DW]), 64'hA4);
    repeat (2) drive(1'b0, 2'd0, '0, 4'hF);

    // Concurrent push and pop on channel 1
    drive(1'b1, 2'd1, 32'hC0, 4'h0);
    drive(1'b1, 2'd1, 32'hC1, 4'h0);
    drive(1'b1, 2'd1, 32'hBEEF, 4'b0010);
    check("pp_occ1", 64'(bus4.occupancy[1*CW +: CW]), 64'd2);
    check("pp_head", 64'(bus4.dout[1*DW +: DW]), 64'hC1);
    drive(1'b0, 2'd0, '0, 4'b0010);
    check("beef_last", 64'(bus4.dout[1*DW +: DW]), 64'hBEEF);
    drive(1'b0, 2'd0, '0, 4'b0010);
    check("ch1_empty", 64'(bus4.dout_valid[1]), 64'd0);
    drive(1'b0, 2'd0, '0, 4'b0010);

    // Out-of-range address on the 3-port router
    din_en = 1'b1;
    addr   = 2'd3;
    din    = 32'hDEAD;
    rdy    = 4'h0;
    #1;
    check("oor_ready", 64'(bus3.din_ready), 64'd1);
    cycle();
    check("oor_drop_hi", 64'(bus3.drop_err), 64'd1);
    check("oor_occ", 64'(bus3.occupancy), 64'd0);
    drive(1'b0, 2'd0, '0, 4'h0);
    check("oor_drop_lo", 64'(bus3.drop_err), 64'd0);

    // Async reset with channels 0 and 3 holding data
    drive(1'b1, 2'd0, 32'h0A0A, 4'h0);
    drive(1'b1, 2'd3, 32'h3B3B, 4'h0);
    async_reset();
    drive(1'b1, 2'd3, 32'h5555, 4'h0);
    check("post_rst_lane3", 64'(bus4.dout[3*DW +: DW]), 64'h5555);
    check("post_rst_valid", 64'(bus4.dout_valid), 64'b1000);
    drive(1'b0, 2'd0, '0, 4'hF);

    // Randomized traffic with occasional mid-stream resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        async_reset();
      end else begin
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 99) < 40);
        drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/buffered_router.md
Name: buffered_router

Overview:
- Parametrised, clocked successor to the combinational 1-to-4 router.
- Routes one input word stream to NUM_PORTS output channels selected by `addr`.
- Each channel has its own FIFO of FIFO_DEPTH words, with valid/ready handshakes on input and every output.
- Sits between a single producer and NUM_PORTS independent consumers, so one stalled consumer does not block traffic to the others until its own FIFO fills.

Parameters:
- DATA_WIDTH, 32, width of each data word.
- NUM_PORTS, 4, number of output channels; legal range 2..16, need not be a power of two.
- FIFO_DEPTH, 4, words per channel FIFO; power of two, >= 2.
- AW, $clog2(NUM_PORTS), address width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- resetn  input  1  asynchronous active-low reset.
- din  input  DATA_WIDTH  input word.
- din_en  input  1  input valid.
- addr  input  AW  destination channel index.
- din_ready  output  1  input accept; transfer occurs when din_en && din_ready at a clk edge.
- dout  output  NUM_PORTS*DATA_WIDTH  channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- dout_valid  output  NUM_PORTS  per-channel valid (FIFO non-empty).
- dout_ready  input  NUM_PORTS  per-channel consumer ready; pop when dout_valid[k] && dout_ready[k].
- occupancy  output  NUM_PORTS*($clog2(FIFO_DEPTH)+1)  per-channel word count, 0..FIFO_DEPTH.
- drop_err  output  1  one-cycle pulse: a word with out-of-range addr was discarded.

Behaviour:
- Reset (resetn low, asynchronous):
  - All FIFO pointers and counts go to 0, so every occupancy is 0 and dout_valid is 0.
  - dout is all zeros and drop_err is 0.
  - FIFO storage contents are don't-care.
- din_ready is combinational:
  - = !full[addr] when addr < NUM_PORTS.
  - = 1 when addr >= NUM_PORTS.
  - It depends only on full, not on a same-cycle pop. A full FIFO refuses input even if it is being popped that cycle.
- Push: on a clk edge with din_en && din_ready && addr < NUM_PORTS, din is written to FIFO[addr] and its count increments.
- Out-of-range address: when din_en && addr >= NUM_PORTS, the word is accepted and discarded. drop_err is registered high for exactly the next cycle; no FIFO changes.
- Output is first-word fall-through:
  - dout lane k shows FIFO[k] head whenever dout_valid[k] = 1.
  - dout lane k is forced to zero when dout_valid[k] = 0, preserving the legacy "disabled output reads 0" rule.
- Latency: a word pushed at edge T gives dout_valid[k] = 1 and the word on lane k from just after edge T. Minimum one cycle input-to-output; no combinational din-to-dout path.
- Pop: on a clk edge with dout_valid[k] && dout_ready[k], FIFO[k] advances and its count decrements. Asserting dout_ready[k] while empty has no effect.
- Simultaneous push and pop on the same channel (non-full, non-empty): count unchanged, both pointers advance.
- Simultaneous push and pop on the same channel when empty: push only (pop gated by valid); count becomes 1.
- Pointer wrap: read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. full means count == FIFO_DEPTH; empty means count == 0.
- Ordering: words to the same channel leave in arrival order. No ordering is guaranteed across channels.
- Independence: channels are independent; all channels may pop in the same cycle.
- din_en low: no state change; din_ready still reflects addr.
- Reset mid-operation: all in-flight words are lost. Outputs reach reset values immediately on resetn falling, without waiting for clk.

Test Plan:
- Reset then idle, din_en = 0 for 5 cycles -> dout_valid = 0000, dout all zero, occupancy all 0, drop_err = 0.
- Push 32'h1111_0000 to addr 0, 32'h2222_0000 to addr 1, 32'h3333_0000 to addr 2, 32'h4444_0000 to addr 3 on consecutive cycles, with dout_ready = 0000 -> each lane shows its word one edge after its push. dout_valid = 1111 and occupancy = 1 per channel.
- Fill a channel: dout_ready[2] = 0, push 32'hA0..A3 then a fifth word to addr 2 -> occupancy[2] = 4, din_ready = 0 on the fifth attempt. Raising dout_ready[2] for 4 cycles drains A0, A1, A2, A3 in order; the fifth word is pushed once din_ready returns 1.
- Concurrent push and pop: channel 1 holds 2 words, push 32'hBEEF to addr 1 with dout_ready[1] = 1 -> occupancy[1] stays 2 and the head advances. After 3 more pops, 32'hBEEF appears last.
- Out-of-range address: NUM_PORTS = 3, push 32'hDEAD with addr = 3 -> din_ready = 1, drop_err high for one cycle, no occupancy change.
- Async reset mid-stream: assert resetn low between clock edges while channels 0 and 3 are non-empty -> dout_valid = 0 and dout = 0 before the next edge. After release, a first push to addr 3 appears normally.
